// File: rtl/console_decimal_formatter.sv
// -----------------------------------------------------------------------------
// console_decimal_formatter
//
// Takes one binary word and prints it as decimal ASCII text. The output is an
// optional '-' sign, then the digits most significant first with no leading
// zeros, then an optional terminator character (LF by default). Intended to
// sit between a value producer and an 8-bit console output stream.
//
// The magnitude is converted by repeated restoring division by 10. Each
// quotient bit takes one cycle, so each digit costs exactly `bits` cycles.
// Remainders are pushed into a small digit buffer, least significant digit at
// index 0. The buffer is then emitted from the top down.
//
// Handshake (both streams): a transfer happens on a rising clk edge where
// stb and ack are both 1. The producer raises stb with stable data and holds
// both until that edge. The consumer's ack may be high before stb rises; only
// coincidence with stb transfers. out1/out1_stb are registered.
//
// Ports:
//   clk        in   1     clock, all logic on the rising edge
//   rst        in   1     synchronous reset, active-high
//   in1        in   bits  value to print
//   in1_stb    in   1     in1 valid
//   in1_ack    out  1     ready to accept in1 (high only in IDLE)
//   out1       out  8     ASCII character
//   out1_stb   out  1     out1 valid
//   out1_ack   in   1     consumer accepts out1
//   state_dbg  out  3     current FSM state (IDLE=0 CONVERT=1 SIGN=2 EMIT=3 TERM=4)
//
// Parameters:
//   bits         input word width, 4..32
//   signed_mode  1 = in1 is two's complement, negatives print a '-'
//   digits       digit buffer depth, must satisfy 10^digits > 2^bits
//   terminator   ASCII code appended after the last digit
//   term_en      0 = no terminator character
// -----------------------------------------------------------------------------
module console_decimal_formatter #(
    parameter int         bits        = 16,
    parameter int         signed_mode = 0,
    parameter int         digits      = 5,
    parameter logic [7:0] terminator  = 8'd10,
    parameter int         term_en     = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [bits-1:0] in1,
    input  logic            in1_stb,
    output logic            in1_ack,
    output logic [7:0]      out1,
    output logic            out1_stb,
    input  logic            out1_ack,
    output logic [2:0]      state_dbg
);

    localparam int BCW  = $clog2(bits);
    localparam int CNTW = $clog2(digits + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONVERT = 3'd1,
        SIGN    = 3'd2,
        EMIT    = 3'd3,
        TERM    = 3'd4
    } state_t;

    state_t            state, state_next;
    logic [bits-1:0]   mag, mag_next;         // dividend, becomes quotient
    logic [3:0]        rem, rem_next;         // partial remainder, always < 10
    logic [BCW-1:0]    bit_cnt, bit_cnt_next; // quotient bit within a pass
    logic [CNTW-1:0]   count, count_next;     // digits held in the buffer
    logic              neg, neg_next;
    logic [3:0]        dbuf [digits];
    logic              push_en;

    logic [7:0]        out1_next;
    logic              out1_stb_next;

    // Capture-side sign/magnitude split. Negation is taken as an unsigned
    // bits-wide value so the most negative input yields 2^(bits-1).
    logic              in_neg;
    logic [bits-1:0]   in_mag;

    // One restoring-division step.
    logic [4:0]        trial;
    logic [4:0]        trial_sub;
    logic              trial_ge;
    logic [3:0]        step_rem;
    logic [bits-1:0]   step_q;
    logic              last_step;

    logic              transfer;
    logic [CNTW-1:0]   sel_idx;
    logic [3:0]        emit_digit;

    assign in1_ack   = (state == IDLE);
    assign state_dbg = state;
    assign transfer  = out1_stb && out1_ack;

    assign in_neg = (signed_mode != 0) && in1[bits-1];
    assign in_mag = in_neg ? (~in1 + {{(bits-1){1'b0}}, 1'b1}) : in1;

    assign trial     = {rem, mag[bits-1]};
    assign trial_sub = trial - 5'd10;
    assign trial_ge  = (trial >= 5'd10);
    assign step_rem  = trial_ge ? trial_sub[3:0] : trial[3:0];
    assign step_q    = {mag[bits-2:0], trial_ge};
    assign last_step = (bit_cnt == BCW'(bits - 1));

    // Next-state and datapath control.
    always_comb begin
        state_next   = state;
        mag_next     = mag;
        rem_next     = rem;
        bit_cnt_next = bit_cnt;
        count_next   = count;
        neg_next     = neg;
        push_en      = 1'b0;

        case (state)
            IDLE: begin
                // in1_ack is high here, so stb alone completes the transfer.
                if (in1_stb) begin
                    mag_next     = in_mag;
                    neg_next     = in_neg;
                    rem_next     = '0;
                    bit_cnt_next = '0;
                    count_next   = '0;
                    state_next   = CONVERT;
                end
            end

            CONVERT: begin
                mag_next = step_q;
                if (last_step) begin
                    // End of a pass: remainder is the next digit, quotient
                    // is the next dividend. A zero quotient ends conversion,
                    // which also makes a zero input take exactly one pass.
                    push_en      = 1'b1;
                    count_next   = count + CNTW'(1);
                    rem_next     = '0;
                    bit_cnt_next = '0;
                    if (step_q == '0) begin
                        state_next = neg ? SIGN : EMIT;
                    end
                end else begin
                    rem_next     = step_rem;
                    bit_cnt_next = bit_cnt + BCW'(1);
                end
            end

            SIGN: begin
                if (transfer) begin
                    state_next = EMIT;
                end
            end

            EMIT: begin
                if (transfer) begin
                    count_next = count - CNTW'(1);
                    if (count == CNTW'(1)) begin
                        state_next = (term_en != 0) ? TERM : IDLE;
                    end
                end
            end

            TERM: begin
                if (transfer) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Digit that will be on display after this edge: the top of the buffer
    // as it will stand once any pop has taken effect.
    always_comb begin
        sel_idx    = count_next - CNTW'(1);
        emit_digit = 4'd0;
        for (int i = 0; i < digits; i++) begin
            if (sel_idx == CNTW'(i)) begin
                emit_digit = dbuf[i];
            end
        end
    end

    // Output register loading. Entering an emitting state leaves out1_stb
    // low for one cycle; the character is loaded on the following edge. On
    // every transfer the next character is loaded in the same edge, giving
    // one character per cycle when the consumer never stalls.
    always_comb begin
        out1_next     = out1;
        out1_stb_next = out1_stb;

        case (state)
            SIGN, EMIT, TERM: begin
                if (!out1_stb || transfer) begin
                    out1_stb_next = (state_next != IDLE);
                    case (state_next)
                        SIGN:    out1_next = 8'h2D;
                        EMIT:    out1_next = 8'h30 + {4'd0, emit_digit};
                        TERM:    out1_next = terminator;
                        default: out1_next = out1;
                    endcase
                end
            end
            default: begin
                out1_stb_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mag      <= '0;
            rem      <= '0;
            bit_cnt  <= '0;
            count    <= '0;
            neg      <= 1'b0;
            out1     <= 8'h00;
            out1_stb <= 1'b0;
        end else begin
            state    <= state_next;
            mag      <= mag_next;
            rem      <= rem_next;
            bit_cnt  <= bit_cnt_next;
            count    <= count_next;
            neg      <= neg_next;
            out1     <= out1_next;
            out1_stb <= out1_stb_next;
        end
    end

    // Digit storage needs no reset: count bounds what is ever read.
    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            for (int i = 0; i < digits; i++) begin
                if (count == CNTW'(i)) begin
                    dbuf[i] <= step_rem;
                end
            end
        end
    end

endmodule
